// File: rtl/note_draw_pkg.sv
// note_draw_pkg: shared FSM states and VGA constants for the note lane drawer
package note_draw_pkg;
  typedef enum logic [1:0] {IDLE, ERASE, DRAW, FINISH} state_t;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int COLOUR_W = 3;
endpackage

// File: rtl/note_rect_scan.sv
// note_rect_scan: row-major W x H tile scan counter, x fastest
// Ports: start clears the scan, advance steps one pixel (wrapping after the last),
// cx/cy give the current pixel, last flags pixel (W-1,H-1).
module note_rect_scan #(
  parameter int W = 16,
  parameter int H = 8
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic       advance,
  output logic [4:0] cx,
  output logic [4:0] cy,
  output logic       last
);
  logic x_end, y_end;
  assign x_end = cx == 5'(W - 1);
  assign y_end = cy == 5'(H - 1);
  assign last = x_end && y_end;
  always_ff @(posedge clk) begin
    if (!resetn || start) begin
      cx <= '0;
      cy <= '0;
    end else if (advance) begin
      cx <= x_end ? '0 : cx + 5'd1;
      cy <= x_end ? (y_end ? '0 : cy + 5'd1) : cy;
    end
  end
endmodule

// File: rtl/note_lane_draw.sv
// note_lane_draw: per-frame erase of the old note tile and redraw at the new y
// Ports: frame_tick/y_in start an update; x_out/y_out/colour/plot stream one pixel
// per cycle to the VGA adapter; busy covers the update; done pulses when it ends.
module note_lane_draw
  import note_draw_pkg::*;
#(
  parameter logic [7:0]          X0          = 8'd120,
  parameter int                  W           = 16,
  parameter int                  H           = 8,
  parameter logic [COLOUR_W-1:0] NOTE_COLOUR = 3'b110,
  parameter logic [COLOUR_W-1:0] BG_COLOUR   = 3'b000,
  parameter int                  SCREEN_H    = note_draw_pkg::SCREEN_H
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                frame_tick,
  input  logic [7:0]          y_in,
  output logic [7:0]          x_out,
  output logic [6:0]          y_out,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  output logic                busy,
  output logic                done
);
  state_t state, state_n;
  logic [7:0] old_y, y_new;
  logic [4:0] cx, cy;
  logic       last, start, advance;
  logic [8:0] row;
  assign start = state == IDLE && frame_tick;
  assign advance = state == ERASE || state == DRAW;
  // 9-bit row so tiles hanging off the bottom clip instead of wrapping to the top
  assign row = {1'b0, state == DRAW ? y_new : old_y} + {4'b0, cy};
  note_rect_scan #(.W(W), .H(H)) u_scan (
    .clk(clk), .resetn(resetn), .start(start), .advance(advance),
    .cx(cx), .cy(cy), .last(last)
  );
  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_n;
  end
  always_comb begin
    state_n = state;
    state_n = state == IDLE  ? (frame_tick ? ERASE : IDLE) :
              state == ERASE ? (last ? DRAW : ERASE) :
              state == DRAW  ? (last ? FINISH : DRAW) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      x_out  <= '0;
      y_out  <= '0;
      colour <= '0;
      plot   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      old_y  <= '0;
      y_new  <= '0;
    end else begin
      done <= state == FINISH;
      busy <= state_n != IDLE;
      plot <= advance && row < 9'(SCREEN_H);
      if (advance) begin
        x_out  <= X0 + {3'b0, cx};
        y_out  <= row[6:0];
        colour <= state == DRAW ? NOTE_COLOUR : BG_COLOUR;
      end
      if (start) y_new <= y_in;
      if (state == DRAW && last) old_y <= y_new;
    end
  end
endmodule

// File: tb/tb_note_lane_draw.sv
// tb_note_lane_draw: directed stimulus against a pixel-list model of the lane drawer
module tb_note_lane_draw;
  localparam int W = 16;
  localparam int H = 8;
  localparam int X0 = 120;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    logic       p;
  } pix_t;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       frame_tick = 1'b0;
  logic [7:0] y_in = '0;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour;
  logic       plot, busy, done;

  note_lane_draw dut (
    .clk(clk), .resetn(resetn), .frame_tick(frame_tick), .y_in(y_in),
    .x_out(x_out), .y_out(y_out), .colour(colour), .plot(plot),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0, n_fail = 0;
  int n_plot = 0, n_busy = 0, n_done = 0;
  logic [2:0] fb [0:159][0:127];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end else n_pass++;
  endtask

  // Model: a frame is just the list of erase pixels then draw pixels, one per cycle.
  pix_t q[$];
  bit started = 0, active = 0, m_pix = 0;
  logic [7:0] m_old = 0, m_x = 0;
  logic [6:0] m_y = 0;
  logic [2:0] m_c = 0;
  logic m_plot = 0, m_busy = 0, m_done = 0;

  task automatic build(input logic [7:0] ybase, input logic [2:0] c);
    for (int r = 0; r < H; r++)
      for (int k = 0; k < W; k++) begin
        int yy;
        pix_t p;
        yy = int'(ybase) + r;
        p.x = 8'(X0 + k);
        p.y = 7'(yy);
        p.c = c;
        p.p = yy < 120;
        q.push_back(p);
      end
  endtask

  always @(posedge clk) begin
    pix_t p;
    started = 1;
    m_pix = 0;
    if (!resetn) begin
      active = 0; q.delete(); m_old = 0;
      m_x = 0; m_y = 0; m_c = 0; m_plot = 0; m_busy = 0; m_done = 0; m_pix = 1;
    end else if (active) begin
      if (q.size() > 0) begin
        p = q.pop_front();
        m_x = p.x; m_y = p.y; m_c = p.c; m_plot = p.p;
        m_busy = 1; m_done = 0; m_pix = 1;
      end else begin
        m_plot = 0; m_busy = 0; m_done = 1; active = 0;
      end
    end else begin
      m_done = 0; m_plot = 0;
      if (frame_tick) begin
        active = 1; m_busy = 1;
        build(m_old, 3'b000);
        build(y_in, 3'b110);
        m_old = y_in;
      end
    end
  end

  initial begin
    for (int i = 0; i < 160; i++)
      for (int j = 0; j < 128; j++) fb[i][j] = 3'b000;
    forever begin
      @(negedge clk);
      if (started) begin
        chk("plot", 32'(plot), 32'(m_plot));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("done", 32'(done), 32'(m_done));
        if (m_pix) begin
          chk("x_out", 32'(x_out), 32'(m_x));
          chk("y_out", 32'(y_out), 32'(m_y));
          chk("colour", 32'(colour), 32'(m_c));
        end
        if (plot === 1'b1) fb[x_out][y_out] = colour;
        n_plot += int'(plot === 1'b1);
        n_busy += int'(busy === 1'b1);
        n_done += int'(done === 1'b1);
      end
    end
  end

  int p0, b0, d0;

  task automatic tick(input logic [7:0] y);
    @(negedge clk);
    p0 = n_plot; b0 = n_busy; d0 = n_done;
    frame_tick = 1'b1;
    y_in = y;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic wait_done;
    int n;
    n = 0;
    while (done !== 1'b1 && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk("done_timeout", 32'(done === 1'b1), 32'd1);
    @(negedge clk);
  endtask

  task automatic frame(input logic [7:0] y, input int exp_plots);
    tick(y);
    wait_done();
    chk("plots", 32'(n_plot - p0), 32'(exp_plots));
    chk("busy_len", 32'(n_busy - b0), 32'd257);
    chk("done_cnt", 32'(n_done - d0), 32'd1);
  endtask

  initial begin
    int bad;
    repeat (3) @(negedge clk);
    chk("rst_x", 32'(x_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    resetn = 1'b1;

    tick(8'd40);
    @(negedge clk);
    chk("first_erase_y", 32'(y_out), 32'd0);
    chk("first_erase_x", 32'(x_out), 32'd120);
    chk("first_erase_plot", 32'(plot), 32'd1);
    wait_done();
    chk("f1_plots", 32'(n_plot - p0), 32'd256);
    chk("f1_busy", 32'(n_busy - b0), 32'd257);
    chk("f1_tile", 32'(fb[120][40]), 32'd6);
    chk("f1_corner", 32'(fb[135][47]), 32'd6);
    chk("f1_below", 32'(fb[120][48]), 32'd0);

    frame(8'd41, 256);
    chk("f2_top_erased", 32'(fb[125][40]), 32'd0);
    chk("f2_bottom", 32'(fb[125][48]), 32'd6);
    frame(8'd115, 128 + 80);
    chk("clip_row119", 32'(fb[130][119]), 32'd6);
    frame(8'd10, 80 + 128);
    chk("clip_erased", 32'(fb[130][119]), 32'd0);

    tick(8'd20);
    frame_tick = 1'b1;
    y_in = 8'd99;
    repeat (100) @(negedge clk);
    frame_tick = 1'b0;
    wait_done();
    chk("held_done_cnt", 32'(n_done - d0), 32'd1);
    chk("held_plots", 32'(n_plot - p0), 32'd256);
    chk("held_tile", 32'(fb[121][27]), 32'd6);

    tick(8'd30);
    repeat (50) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    chk("abort_plot", 32'(plot), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    tick(8'd5);
    @(negedge clk);
    chk("post_abort_erase_y", 32'(y_out), 32'd0);
    chk("post_abort_colour", 32'(colour), 32'd0);
    wait_done();

    frame(8'd60, 256);
    frame(8'd60, 256);
    bad = 0;
    for (int r = 60; r < 68; r++)
      for (int k = 120; k < 136; k++) bad += int'(fb[k][r] !== 3'b110);
    chk("same_y_tile_bad", 32'(bad), 32'd0);
    chk("same_y_above", 32'(fb[120][59]), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
